// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the instruction control sequencer: opcode values,
// T-state encoding, instruction classes, ALU function codes and the packed
// control word driven onto the datapath strobes.
// Optional build macro: SINGLE_STEP_EN adds the PAUSE state.
package cpu_ctrl_pkg;

    localparam int OPC_W = 5;
    localparam int ALU_W = 5;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // The ALU is driven with the ISA opcode of the matching register operation
    localparam logic [ALU_W-1:0] ALU_ADD = OP_ADD;
    localparam logic [ALU_W-1:0] ALU_SUB = OP_SUB;
    localparam logic [ALU_W-1:0] ALU_AND = OP_AND;
    localparam logic [ALU_W-1:0] ALU_OR  = OP_OR;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_T0,
        ST_T1,
        ST_T2,
        ST_DEC,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_T7,
`ifdef SINGLE_STEP_EN
        ST_PAUSE,
`endif
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RTYPE,
        CL_ITYPE,
        CL_LD,
        CL_LDI,
        CL_ST,
        CL_BR,
        CL_NOP,
        CL_HALT,
        CL_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic             gra;
        logic             grb;
        logic             grc;
        logic             rin;
        logic             rout;
        logic             baout;
        logic             cout;
        logic             pcout;
        logic             pcin;
        logic             incpc;
        logic             marin;
        logic             mdrin;
        logic             mdrout;
        logic             irin;
        logic             yin;
        logic             zin;
        logic             zlowout;
        logic             conin;
        logic             read;
        logic             write;
        logic [ALU_W-1:0] alu_op;
        logic             halted;
        logic             illegal_op;
    } ctrl_word_t;

    // Map an opcode onto the microcode sequence it follows
    function automatic op_class_t classify(input logic [OPC_W-1:0] opc);
        op_class_t cls;
        cls = CL_ILLEGAL;
        case (opc)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CL_RTYPE;
            OP_ADDI, OP_ANDI, OP_ORI:      cls = CL_ITYPE;
            OP_LD:                         cls = CL_LD;
            OP_LDI:                        cls = CL_LDI;
            OP_ST:                         cls = CL_ST;
            OP_BR:                         cls = CL_BR;
            OP_NOP:                        cls = CL_NOP;
            OP_HALT:                       cls = CL_HALT;
            default:                       cls = CL_ILLEGAL;
        endcase
        return cls;
    endfunction

    // Immediate forms reuse the ALU function of their register counterpart
    function automatic logic [ALU_W-1:0] imm_alu_op(input logic [OPC_W-1:0] opc);
        logic [ALU_W-1:0] op;
        op = ALU_ADD;
        case (opc)
            OP_ANDI: op = ALU_AND;
            OP_ORI:  op = ALU_OR;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ctrl_word_decode.sv
// Combinational decode of the current T-state, the opcode held in the IR and
// the branch condition into one control word for the datapath.
// Optional build macro: SINGLE_STEP_EN (PAUSE decodes to an all-zero word).
module ctrl_word_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t           state,
    input  logic [OPC_W-1:0] opcode,
    input  logic             con_ff,
    output ctrl_word_t       cw
);

    op_class_t op_class;

    assign op_class = classify(opcode);

    // Strobes for the active T-state; anything not listed stays low
    always_comb begin
        cw = '0;
        case (state)
            ST_T0: begin
                cw.pcout  = 1'b1;
                cw.marin  = 1'b1;
                cw.incpc  = 1'b1;
                cw.zin    = 1'b1;
                cw.alu_op = ALU_ADD;
            end
            ST_T1: begin
                cw.zlowout = 1'b1;
                cw.pcin    = 1'b1;
                cw.read    = 1'b1;
                cw.mdrin   = 1'b1;
            end
            ST_T2: begin
                cw.mdrout = 1'b1;
                cw.irin   = 1'b1;
            end
            ST_DEC: begin
                cw.illegal_op = (op_class == CL_ILLEGAL);
            end
            ST_T3: begin
                case (op_class)
                    CL_RTYPE, CL_ITYPE: begin
                        cw.grb  = 1'b1;
                        cw.rout = 1'b1;
                        cw.yin  = 1'b1;
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        cw.grb   = 1'b1;
                        cw.baout = 1'b1;
                        cw.yin   = 1'b1;
                    end
                    CL_BR: begin
                        cw.gra   = 1'b1;
                        cw.rout  = 1'b1;
                        cw.conin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (op_class)
                    CL_RTYPE: begin
                        cw.grc    = 1'b1;
                        cw.rout   = 1'b1;
                        cw.zin    = 1'b1;
                        cw.alu_op = opcode;
                    end
                    CL_ITYPE: begin
                        cw.cout   = 1'b1;
                        cw.zin    = 1'b1;
                        cw.alu_op = imm_alu_op(opcode);
                    end
                    CL_LD, CL_LDI, CL_ST: begin
                        cw.cout   = 1'b1;
                        cw.zin    = 1'b1;
                        cw.alu_op = ALU_ADD;
                    end
                    CL_BR: begin
                        cw.pcout = 1'b1;
                        cw.yin   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (op_class)
                    CL_RTYPE, CL_ITYPE, CL_LDI: begin
                        cw.zlowout = 1'b1;
                        cw.gra     = 1'b1;
                        cw.rin     = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        cw.zlowout = 1'b1;
                        cw.marin   = 1'b1;
                    end
                    CL_BR: begin
                        cw.cout   = 1'b1;
                        cw.zin    = 1'b1;
                        cw.alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (op_class)
                    CL_LD: begin
                        cw.read  = 1'b1;
                        cw.mdrin = 1'b1;
                    end
                    CL_ST: begin
                        cw.gra   = 1'b1;
                        cw.rout  = 1'b1;
                        cw.mdrin = 1'b1;
                    end
                    CL_BR: begin
                        // Branch target only reaches the PC when taken
                        cw.zlowout = con_ff;
                        cw.pcin    = con_ff;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (op_class)
                    CL_LD: begin
                        cw.mdrout = 1'b1;
                        cw.gra    = 1'b1;
                        cw.rin    = 1'b1;
                    end
                    CL_ST: begin
                        cw.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_HALT: begin
                cw.halted = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: steps through the fetch T-states, decodes the IR
// opcode and walks the per-class execute T-states, driving the datapath
// register selects and strobes from the state register.
// Optional build macro: SINGLE_STEP_EN adds the step input and a PAUSE state
// entered after every instruction.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             run,
    input  logic [31:0]      ir,
    input  logic             con_ff,
    input  logic             mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic             step,
`endif
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic             Cout,
    output logic             PCout,
    output logic             PCin,
    output logic             IncPC,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Zlowout,
    output logic             CONin,
    output logic             Read,
    output logic             Write,
    output logic [ALU_W-1:0] alu_op,
    output logic             halted,
    output logic             illegal_op
);

`ifdef SINGLE_STEP_EN
    localparam state_t INSTR_DONE = ST_PAUSE;
`else
    localparam state_t INSTR_DONE = ST_T0;
`endif

    state_t           state;
    logic [OPC_W-1:0] opcode;
    op_class_t        op_class;
    ctrl_word_t       cw;
    logic             ir_unused;

    assign opcode    = ir[31:27];
    assign op_class  = classify(opcode);
    // Register fields are consumed by the datapath, not by the sequencer
    assign ir_unused = ^ir[26:0];

    // State register with next-state selection; reset aborts any instruction
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state <= run ? ST_T0 : ST_IDLE;
                ST_T0:   state <= ST_T1;
                ST_T1:   state <= mem_ready ? ST_T2 : ST_T1;
                ST_T2:   state <= ST_DEC;
                ST_DEC: begin
                    case (op_class)
                        CL_NOP, CL_ILLEGAL: state <= INSTR_DONE;
                        CL_HALT:            state <= ST_HALT;
                        default:            state <= ST_T3;
                    endcase
                end
                ST_T3:   state <= ST_T4;
                ST_T4:   state <= ST_T5;
                ST_T5: begin
                    case (op_class)
                        CL_LD, CL_ST, CL_BR: state <= ST_T6;
                        default:             state <= INSTR_DONE;
                    endcase
                end
                ST_T6: begin
                    case (op_class)
                        CL_LD:   state <= mem_ready ? ST_T7 : ST_T6;
                        CL_ST:   state <= ST_T7;
                        default: state <= INSTR_DONE;
                    endcase
                end
                ST_T7: begin
                    if (op_class == CL_ST && !mem_ready) begin
                        state <= ST_T7;
                    end else begin
                        state <= INSTR_DONE;
                    end
                end
`ifdef SINGLE_STEP_EN
                ST_PAUSE: state <= step ? ST_T0 : ST_PAUSE;
`endif
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

    ctrl_word_decode u_decode (
        .state  (state),
        .opcode (opcode),
        .con_ff (con_ff),
        .cw     (cw)
    );

    assign Gra        = cw.gra;
    assign Grb        = cw.grb;
    assign Grc        = cw.grc;
    assign Rin        = cw.rin;
    assign Rout       = cw.rout;
    assign BAout      = cw.baout;
    assign Cout       = cw.cout;
    assign PCout      = cw.pcout;
    assign PCin       = cw.pcin;
    assign IncPC      = cw.incpc;
    assign MARin      = cw.marin;
    assign MDRin      = cw.mdrin;
    assign MDRout     = cw.mdrout;
    assign IRin       = cw.irin;
    assign Yin        = cw.yin;
    assign Zin        = cw.zin;
    assign Zlowout    = cw.zlowout;
    assign CONin      = cw.conin;
    assign Read       = cw.read;
    assign Write      = cw.write;
    assign alu_op     = cw.alu_op;
    assign halted     = cw.halted;
    assign illegal_op = cw.illegal_op;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. A reference model expands each
// instruction into its cycle-by-cycle control words; a driver applies the
// per-cycle inputs and queues the expected word; a monitor compares on the
// falling edge. Honours SINGLE_STEP_EN when defined.
module tb_control_sequencer;

    localparam logic [4:0] M_LD = 5'b00000, M_LDI = 5'b00001, M_ST = 5'b00010;
    localparam logic [4:0] M_ADD = 5'b00011, M_SUB = 5'b00100, M_AND = 5'b00101;
    localparam logic [4:0] M_OR = 5'b00110, M_ADDI = 5'b01100, M_ANDI = 5'b01101;
    localparam logic [4:0] M_ORI = 5'b01110, M_BR = 5'b10010, M_NOP = 5'b11010;
    localparam logic [4:0] M_HALT = 5'b11011;

    localparam logic [26:0] GRA = 27'h1, GRB = 27'h2, GRC = 27'h4, RIN = 27'h8;
    localparam logic [26:0] ROUT = 27'h10, BAOUT = 27'h20, COUT = 27'h40, PCOUT = 27'h80;
    localparam logic [26:0] PCIN = 27'h100, INCPC = 27'h200, MARIN = 27'h400, MDRIN = 27'h800;
    localparam logic [26:0] MDROUT = 27'h1000, IRIN = 27'h2000, YIN = 27'h4000, ZIN = 27'h8000;
    localparam logic [26:0] ZLOWOUT = 27'h10000, CONIN = 27'h20000, READ = 27'h40000;
    localparam logic [26:0] WRITE = 27'h80000, HALTED = 27'h2000000, ILLEGAL = 27'h4000000;

    logic        clock = 1'b0;
    logic        reset_n, run, con_ff, mem_ready;
    logic [31:0] ir;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin;
    logic MDRin, MDRout, IRin, Yin, Zin, Zlowout, CONin, Read, Write;
    logic [4:0] alu_op;
    logic halted, illegal_op;

    always #5 clock = ~clock;

    control_sequencer dut (
        .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .con_ff(con_ff),
        .mem_ready(mem_ready),
`ifdef SINGLE_STEP_EN
        .step(step),
`endif
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Zlowout(Zlowout), .CONin(CONin), .Read(Read), .Write(Write),
        .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op)
    );

    typedef struct {
        logic        rst;
        logic        run;
        logic [31:0] ir;
        logic        con;
        logic        mr;
        logic        stp;
        logic [26:0] exp;
        int          tag;
    } cyc_t;

    cyc_t        stim_q[$];
    logic [26:0] exp_q[$];
    int          tag_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc_n  = 0;
    logic [31:0] cur_ir = 32'd0;
    logic        cur_con = 1'b0;
    int          cur_tag = 0;
    int          pause_n = 0;

    function automatic logic [26:0] aluf(input logic [4:0] v);
        return {2'b00, v, 20'd0};
    endfunction

    function automatic bit is_legal(input logic [4:0] o);
        return o inside {M_LD, M_LDI, M_ST, M_ADD, M_SUB, M_AND, M_OR,
                         M_ADDI, M_ANDI, M_ORI, M_BR, M_NOP, M_HALT};
    endfunction

    // One cycle of stimulus; negative selectors mean "don't care, randomize"
    task automatic put(input logic [26:0] e, input int mr, input int rn,
                       input int stp, input logic rst);
        cyc_t c;
        c.rst = rst;
        c.ir  = cur_ir;
        c.con = cur_con;
        c.mr  = (mr  < 0) ? 1'($urandom_range(0, 1)) : 1'(mr);
        c.run = (rn  < 0) ? 1'($urandom_range(0, 1)) : 1'(rn);
        c.stp = (stp < 0) ? 1'($urandom_range(0, 1)) : 1'(stp);
        c.exp = e;
        c.tag = cur_tag;
        stim_q.push_back(c);
    endtask

    task automatic add(input logic [26:0] e);
        put(e, -1, -1, -1, 1'b1);
    endtask

    task automatic gen_idle(input int n);
        repeat (n) put(27'd0, -1, 0, -1, 1'b1);
        put(27'd0, -1, 1, -1, 1'b1);
    endtask

    task automatic gen_reset(input int n);
        repeat (n) put(27'd0, -1, -1, -1, 1'b0);
    endtask

    // Expected control-word sequence of one instruction, fetch to completion
    task automatic gen_instr(input logic [31:0] instr, input int w1, input int wm,
                             input logic con);
        logic [4:0]  o;
        logic [26:0] fetch1;
        o       = instr[31:27];
        cur_ir  = instr;
        cur_con = con;
        cur_tag++;
        fetch1  = ZLOWOUT | PCIN | READ | MDRIN;
        add(PCOUT | MARIN | INCPC | ZIN | aluf(M_ADD));
        repeat (w1) put(fetch1, 0, -1, -1, 1'b1);
        put(fetch1, 1, -1, -1, 1'b1);
        add(MDROUT | IRIN);
        add(is_legal(o) ? 27'd0 : ILLEGAL);
        if (o inside {M_ADD, M_SUB, M_AND, M_OR, M_ADDI, M_ANDI, M_ORI}) begin
            add(GRB | ROUT | YIN);
            if (o == M_ADDI)      add(COUT | ZIN | aluf(M_ADD));
            else if (o == M_ANDI) add(COUT | ZIN | aluf(M_AND));
            else if (o == M_ORI)  add(COUT | ZIN | aluf(M_OR));
            else                  add(GRC | ROUT | ZIN | aluf(o));
            add(ZLOWOUT | GRA | RIN);
        end else if (o inside {M_LD, M_LDI, M_ST}) begin
            add(GRB | BAOUT | YIN);
            add(COUT | ZIN | aluf(M_ADD));
            if (o == M_LDI) begin
                add(ZLOWOUT | GRA | RIN);
            end else begin
                add(ZLOWOUT | MARIN);
                if (o == M_LD) begin
                    repeat (wm) put(READ | MDRIN, 0, -1, -1, 1'b1);
                    put(READ | MDRIN, 1, -1, -1, 1'b1);
                    add(MDROUT | GRA | RIN);
                end else begin
                    add(GRA | ROUT | MDRIN);
                    repeat (wm) put(WRITE, 0, -1, -1, 1'b1);
                    put(WRITE, 1, -1, -1, 1'b1);
                end
            end
        end else if (o == M_BR) begin
            add(GRA | ROUT | CONIN);
            add(PCOUT | YIN);
            add(COUT | ZIN | aluf(M_ADD));
            add(con ? (ZLOWOUT | PCIN) : 27'd0);
        end else if (o == M_HALT) begin
            repeat (20) put(HALTED, -1, 1, -1, 1'b1);
        end
`ifdef SINGLE_STEP_EN
        if (o != M_HALT) begin
            repeat (pause_n) put(27'd0, -1, -1, 0, 1'b1);
            put(27'd0, -1, -1, 1, 1'b1);
        end
`endif
    endtask

    function automatic logic [4:0] rand_opc();
        logic [4:0] pool [12];
        logic [4:0] o;
        pool = '{M_LD, M_LDI, M_ST, M_ADD, M_SUB, M_AND, M_OR,
                 M_ADDI, M_ANDI, M_ORI, M_BR, M_NOP};
        if ($urandom_range(0, 7) == 0) begin
            o = 5'($urandom_range(0, 31));
            while (is_legal(o)) o = 5'($urandom_range(0, 31));
        end else begin
            o = pool[$urandom_range(0, 11)];
        end
        return o;
    endfunction

    // Monitor: compare the DUT control word against the oldest expectation
    logic [26:0] mon_exp, mon_act;
    int          mon_tag;
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_tag = tag_q.pop_front();
            mon_act = {illegal_op, halted, alu_op, Write, Read, CONin, Zlowout, Zin,
                       Yin, IRin, MDRout, MDRin, MARin, IncPC, PCin, PCout, Cout,
                       BAout, Rout, Rin, Grc, Grb, Gra};
            checks++;
            if (mon_act !== mon_exp) begin
                errors++;
                $display("FAIL ctrl_word instr%0d cyc%0d actual=%h required=%h",
                         mon_tag, cyc_n, mon_act, mon_exp);
            end
            cyc_n++;
        end
    end

    initial begin
        cyc_t c;
        int   base;
        reset_n   = 1'b0;
        run       = 1'b0;
        ir        = 32'd0;
        con_ff    = 1'b0;
        mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
        step      = 1'b0;
`endif
        // Reset state, then a directed instruction mix
        gen_reset(2);
        gen_idle(2);
        pause_n = 2;
        gen_instr({M_ADD, 4'd1, 4'd2, 4'd3, 15'd0}, 0, 0, 1'b0);
        gen_instr({M_LD, 27'($urandom)}, 1, 3, 1'b1);
        gen_instr({M_ST, 27'($urandom)}, 0, 2, 1'b0);
        gen_instr({M_BR, 27'($urandom)}, 0, 0, 1'b0);
        gen_instr({M_BR, 27'($urandom)}, 0, 0, 1'b1);
        gen_instr({5'b11111, 27'($urandom)}, 0, 0, 1'b0);
        gen_instr({M_LDI, 27'($urandom)}, 2, 0, 1'b1);
        pause_n = 5;
        gen_instr({M_NOP, 27'd0}, 0, 0, 1'b0);
        gen_instr({M_NOP, 27'd0}, 0, 0, 1'b0);
        // ADD aborted by reset in T4; nothing more until run returns
        base = stim_q.size();
        gen_instr({M_ADD, 4'd4, 4'd5, 4'd6, 15'd0}, 0, 0, 1'b0);
        while (stim_q.size() > base + 5) void'(stim_q.pop_back());
        gen_reset(1);
        gen_idle(3);
        // Randomized instruction stream
        for (int i = 0; i < 30; i++) begin
            pause_n = $urandom_range(0, 3);
            gen_instr({rand_opc(), 27'($urandom)}, $urandom_range(0, 2),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        // HALT sticks despite run; only reset recovers
        gen_instr({M_HALT, 27'($urandom)}, 0, 0, 1'b0);
        gen_reset(1);
        gen_idle(1);
        pause_n = 0;
        gen_instr({M_ORI, 27'($urandom)}, 0, 0, 1'b0);

        // Driver: one stimulus entry per clock, applied just after the edge
        @(posedge clock);
        #1;
        while (stim_q.size() > 0) begin
            c = stim_q.pop_front();
            reset_n   = c.rst;
            run       = c.run;
            ir        = c.ir;
            con_ff    = c.con;
            mem_ready = c.mr;
`ifdef SINGLE_STEP_EN
            step      = c.stp;
`endif
            exp_q.push_back(c.exp);
            tag_q.push_back(c.tag);
            @(posedge clock);
            #1;
        end
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
